// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM states, grant encoding,
// default bus widths.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_D    = 2'd2
  } gnt_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational request picker for mem_arbiter.
// Optional feature macro: MEM_ARB_FAIR_EN (round-robin on ties; otherwise
// data always beats fetch).
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic if_req,
  input  logic d_req,
  input  logic if_mask,
  input  logic d_mask,
`ifdef MEM_ARB_FAIR_EN
  input  logic last_d,
`endif
  output gnt_t gnt
);

  logic if_ok;
  logic d_ok;

  assign if_ok = if_req & ~if_mask;
  assign d_ok  = d_req & ~d_mask;

  // Select the winning requester among unmasked requests
  always_comb begin
    gnt = GNT_NONE;
    if (d_ok && if_ok) begin
`ifdef MEM_ARB_FAIR_EN
      gnt = last_d ? GNT_IF : GNT_D;
`else
      gnt = GNT_D;
`endif
    end else if (d_ok) begin
      gnt = GNT_D;
    end else if (if_ok) begin
      gnt = GNT_IF;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serializes fetch and LW/SW accesses onto the single unified memory and
// generates the pipeline stall.
// Optional feature macro: MEM_ARB_FAIR_EN (round-robin tie break with a
// 1-bit last-grant register reset to "fetch").
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_data,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic              stall
);

  state_t state;
  gnt_t   gnt;
  gnt_t   pick;

`ifdef MEM_ARB_FAIR_EN
  logic last_d;
`endif

  // A requester whose ack is high this cycle is masked so its held request
  // is not granted twice.
  mem_arb_pick u_pick (
    .if_req  (if_req),
    .d_req   (d_req),
    .if_mask (if_ack),
    .d_mask  (d_ack),
`ifdef MEM_ARB_FAIR_EN
    .last_d  (last_d),
`endif
    .gnt     (pick)
  );

  assign stall = (if_req & ~if_ack) | (d_req & ~d_ack);

  // Transaction sequencer: grant, issue strobe, wait for completion, ack
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= GNT_NONE;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_data   <= '0;
      d_rdata   <= '0;
    end else begin
      mem_en <= 1'b0;
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (pick != GNT_NONE) begin
            state  <= ISSUE;
            gnt    <= pick;
            mem_en <= 1'b1;
            if (pick == GNT_D) begin
              mem_addr  <= d_addr;
              mem_we    <= d_we;
              mem_wdata <= d_wdata;
            end else begin
              mem_addr  <= if_addr;
              mem_we    <= 1'b0;
              mem_wdata <= '0;
            end
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (mem_valid) begin
            state <= IDLE;
            gnt   <= GNT_NONE;
            if (gnt == GNT_IF) begin
              if_data <= mem_rdata;
              if_ack  <= 1'b1;
            end else if (gnt == GNT_D) begin
              d_ack <= 1'b1;
              if (!mem_we) begin
                d_rdata <= mem_rdata;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= GNT_NONE;
        end
      endcase
    end
  end

`ifdef MEM_ARB_FAIR_EN
  // Remember which side won the most recent grant
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_d <= 1'b0;
    end else if ((state == IDLE) && (pick != GNT_NONE)) begin
      last_d <= (pick == GNT_D);
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table of single transactions plus
// hand-written tie, reset-in-WAIT and spurious-valid sequences.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_data;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_ack;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_valid;
  logic        stall;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [15:0] last_if;
  logic [15:0] last_d;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_data   (if_data),
    .if_ack    (if_ack),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ack     (d_ack),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_valid (mem_valid),
    .stall     (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_d;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int unsigned lat;
    logic [15:0] rdata;
    logic        exp_we;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for mem_en (unless already seen), check bus, return completion after
  // lat cycles, then check the ack cycle. Ends inside the ack cycle.
  task automatic serve(input string name, input logic exp_d, input logic [15:0] exp_addr,
                       input logic exp_we, input logic [15:0] exp_wdata,
                       input int unsigned lat, input logic [15:0] rdata,
                       input logic [15:0] exp_rd, input logic en_seen);
    int unsigned n;
    logic        found;
    logic        exp_stall;
    n     = 0;
    found = en_seen;
    while (!found && n < 8) begin
      step();
      n++;
      if (mem_en) found = 1'b1;
    end
    if (!found) begin
      chk({name, "/en_timeout"}, 32'd0, 32'd1);
      return;
    end
    if (!en_seen) chk({name, "/en_latency"}, n, 32'd1);
    chk({name, "/addr"}, {16'd0, mem_addr}, {16'd0, exp_addr});
    chk({name, "/we"}, {31'd0, mem_we}, {31'd0, exp_we});
    if (exp_we) chk({name, "/wdata"}, {16'd0, mem_wdata}, {16'd0, exp_wdata});
    for (int unsigned i = 1; i <= lat; i++) begin
      step();
      chk({name, "/hold"},
          {mem_en, if_ack, d_ack, stall, mem_we, 11'd0, mem_addr},
          {1'b0, 1'b0, 1'b0, 1'b1, exp_we, 11'd0, exp_addr});
      if (i == lat) begin
        mem_valid = 1'b1;
        mem_rdata = rdata;
      end
    end
    step();
    mem_valid = 1'b0;
    mem_rdata = 16'h0BAD;
    chk({name, "/acks"}, {30'd0, if_ack, d_ack}, exp_d ? 32'd1 : 32'd2);
    exp_stall = (if_req & exp_d) | (d_req & ~exp_d);
    chk({name, "/stall_at_ack"}, {31'd0, stall}, {31'd0, exp_stall});
    if (exp_d) begin
      chk({name, "/d_rdata"}, {16'd0, d_rdata}, {16'd0, exp_rd});
      chk({name, "/if_data_kept"}, {16'd0, if_data}, {16'd0, last_if});
      last_d = exp_rd;
    end else begin
      chk({name, "/if_data"}, {16'd0, if_data}, {16'd0, exp_rd});
      chk({name, "/d_rdata_kept"}, {16'd0, d_rdata}, {16'd0, last_d});
      last_if = exp_rd;
    end
  endtask

  task automatic quiet(input string name);
    if_req = 1'b0;
    d_req  = 1'b0;
    step();
    chk({name, "/ack_pulse"}, {29'd0, if_ack, d_ack, stall}, 32'd0);
  endtask

  // Simultaneous fetch and load; first_d says which one must be served first.
  task automatic tie(input string name, input logic first_d,
                     input logic [15:0] ia, input logic [15:0] da,
                     input logic [15:0] r1, input logic [15:0] r2);
    if_addr = ia;
    d_addr  = da;
    d_we    = 1'b0;
    if_req  = 1'b1;
    d_req   = 1'b1;
    serve({name, "/first"}, first_d, first_d ? da : ia, 1'b0, 16'h0, 1, r1, r1, 1'b0);
    step();
    if (first_d) d_req = 1'b0; else if_req = 1'b0;
    chk({name, "/second_en"}, {15'd0, mem_en, mem_addr}, {15'd0, 1'b1, first_d ? ia : da});
    serve({name, "/second"}, ~first_d, first_d ? ia : da, 1'b0, 16'h0, 1, r2, r2, 1'b1);
    quiet({name, "/end"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000,  2, 16'hA123, 1'b0, 16'hA123};
    vecs[1] = '{1'b1, 1'b0, 16'h0200, 16'h0000,  1, 16'h5A5A, 1'b0, 16'h5A5A};
    vecs[2] = '{1'b1, 1'b1, 16'h0300, 16'hBEEF,  3, 16'hDEAD, 1'b1, 16'h5A5A};
    vecs[3] = '{1'b0, 1'b1, 16'hFFFF, 16'h1234,  1, 16'h0001, 1'b0, 16'h0001};
    vecs[4] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 20, 16'hC3C3, 1'b0, 16'hC3C3};
    vecs[5] = '{1'b1, 1'b1, 16'hFFFF, 16'h0000,  1, 16'hFFFF, 1'b1, 16'hC3C3};

    rst_n     = 1'b0;
    if_req    = 1'b0;
    if_addr   = 16'h0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    d_addr    = 16'h0;
    d_wdata   = 16'h0;
    mem_rdata = 16'h0;
    mem_valid = 1'b0;
    last_if   = 16'h0;
    last_d    = 16'h0;
    repeat (3) step();
    chk("reset/ctrl", {26'd0, mem_en, mem_we, if_ack, d_ack, stall, 1'b0}, 32'd0);
    chk("reset/bus", {mem_addr, mem_wdata}, 32'd0);
    chk("reset/data", {if_data, d_rdata}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("idle/no_en", {31'd0, mem_en}, 32'd0);

    // First tie after reset: data wins in both builds
    tie("tie1", 1'b1, 16'h0040, 16'h0200, 16'h1111, 16'h2222);

    for (int unsigned k = 0; k < 6; k++) begin
      string nm;
      nm = $sformatf("vec%0d", k);
      if_addr = vecs[k].addr;
      d_addr  = vecs[k].addr;
      d_we    = vecs[k].we;
      d_wdata = vecs[k].wdata;
      if_req  = ~vecs[k].is_d;
      d_req   = vecs[k].is_d;
      serve(nm, vecs[k].is_d, vecs[k].addr, vecs[k].exp_we, vecs[k].wdata,
            vecs[k].lat, vecs[k].rdata, vecs[k].exp_rd, 1'b0);
      quiet(nm);
    end

    // Last grant was data: round-robin gives this tie to fetch
`ifdef MEM_ARB_FAIR_EN
    tie("tie2", 1'b0, 16'h0080, 16'h0400, 16'h3333, 16'h4444);
`else
    tie("tie2", 1'b1, 16'h0080, 16'h0400, 16'h3333, 16'h4444);
`endif

    // Reset while a store is outstanding, then a stray completion
    d_addr  = 16'h0123;
    d_wdata = 16'h9999;
    d_we    = 1'b1;
    d_req   = 1'b1;
    step();
    chk("rstwait/en", {15'd0, mem_en, mem_addr}, {15'd0, 1'b1, 16'h0123});
    step();
    rst_n = 1'b0;
    d_req = 1'b0;
    d_we  = 1'b0;
    step();
    chk("rstwait/ctrl", {27'd0, mem_en, mem_we, if_ack, d_ack, stall}, 32'd0);
    chk("rstwait/bus", {mem_addr, mem_wdata}, 32'd0);
    chk("rstwait/data", {if_data, d_rdata}, 32'd0);
    last_if   = 16'h0;
    last_d    = 16'h0;
    rst_n     = 1'b1;
    mem_valid = 1'b1;
    mem_rdata = 16'h7777;
    step();
    mem_valid = 1'b0;
    chk("rstwait/stray1", {29'd0, mem_en, if_ack, d_ack}, 32'd0);
    step();
    chk("rstwait/stray2", {13'd0, mem_en, if_ack, d_ack, d_rdata}, 32'd0);
    if_addr = 16'h0500;
    if_req  = 1'b1;
    serve("rstwait/next", 1'b0, 16'h0500, 1'b0, 16'h0, 1, 16'h5555, 16'h5555, 1'b0);
    quiet("rstwait/next");

    // Spurious completion while idle
    mem_valid = 1'b1;
    mem_rdata = 16'h6666;
    step();
    mem_valid = 1'b0;
    chk("spur/acks", {29'd0, mem_en, if_ack, d_ack}, 32'd0);
    step();
    chk("spur/data", {if_data, d_rdata}, {last_if, last_d});
    d_addr = 16'h0600;
    d_we   = 1'b0;
    d_req  = 1'b1;
    serve("spur/next", 1'b1, 16'h0600, 1'b0, 16'h0, 1, 16'h6060, 16'h6060, 1'b0);
    quiet("spur/next");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
